mcp_adc_responder: RTL and testbench
====================================

Name: mcp_adc_responder

Overview:
- Synthesizable SPI responder that emulates an MCP3202-style 12-bit, 2-channel ADC.
- It answers the existing MCP SPI master: it samples cs/sclk/din, decodes the start/config bits, and shifts a 12-bit conversion result out on dout.
- It is used for on-board loopback and bench self-check of the temperature path without the physical ADC.
- Channel values come from registers or test logic via ch0_data/ch1_data.

Parameters:
- DATA_W, 12, conversion result width; the bit counters are sized from it.
- SYNC_STAGES, 2, synchronizer depth for cs, sclk and din; minimum 2.

Ports:
- clk  input  1  system clock; must be at least 8x the sclk frequency.
- rst  input  1  synchronous, active-high reset.
- cs  input  1  chip select from the master, active low.
- sclk  input  1  SPI clock from the master, idle low (mode 0,0).
- din  input  1  master-to-ADC serial data, sampled on sclk rising edges.
- dout  output  1  ADC-to-master serial data, changes after sclk falling edges; 0 whenever dout_oe=0.
- dout_oe  output  1  output enable (models high-Z); 1 from the null bit until cs rises.
- ch0_data  input  DATA_W  CH0 analog value.
- ch1_data  input  DATA_W  CH1 analog value.
- busy  output  1  1 while the synchronized cs is low.
- cfg_sgl, cfg_odd, cfg_msbf  output  1 each  config bits of the last decoded command.
- xfer_done  output  1  one-clk pulse when the final data bit has been driven.

Behaviour:
- Reset: all outputs 0; state IDLE; synchronizers cleared to cs=1, sclk=0, din=0.
- Sampling:
  - cs, sclk and din pass through SYNC_STAGES flops.
  - Rising and falling sclk edges are detected from the synchronized sclk and its previous value.
  - dout/dout_oe are registered and update SYNC_STAGES+1 clk after the raw sclk falling edge.
- IDLE: entered whenever synchronized cs=1 (highest priority, from any state). dout_oe=0, bit counter cleared.
- WAIT_START:
  - Entered when synchronized cs=0.
  - Rising edges with din=0 are ignored (leading zeros allowed).
  - A rising edge with din=1 goes to CFG.
- CFG:
  - Captures SGL, ODD and MSBF on three successive rising edges.
  - On the MSBF edge, cfg_* registers update and the result is latched into the shift register (this is the sampling instant).
  - The next state is NULL.
- Result computation:
  - SGL=1: ODD=0 selects ch0_data, ODD=1 selects ch1_data.
  - SGL=0, ODD=0: ch0 minus ch1. SGL=0, ODD=1: ch1 minus ch0.
  - Differential results are computed at DATA_W+1 bits and clamped to 0 when negative; no wrap.
  - Later changes to ch*_data do not affect a transfer in progress.
- NULL: on the next falling edge, dout_oe=1 and dout=0, then go to MSB_OUT.
- MSB_OUT:
  - On each of the next DATA_W falling edges, dout = B11 down to B0.
  - After B0 is driven: MSBF=1 goes to DONE and pulses xfer_done; MSBF=0 goes to LSB_OUT.
- LSB_OUT:
  - On DATA_W-1 further falling edges, dout = B1 up to B11 (B0 is not repeated).
  - After B11 is driven, pulse xfer_done and go to DONE.
- DONE:
  - dout=0, dout_oe=1; further sclk edges are ignored.
  - Stays here until cs rises, then goes to IDLE.
- Abort: cs rising in any state goes to IDLE; dout_oe=0 within SYNC_STAGES+1 clk; no xfer_done; cfg_* keep their last values.
- Simultaneous sclk edge and cs rise in the same synchronized cycle: the cs rise wins.
- A new transfer needs cs to go high then low again; every transfer re-samples the channels.
- rst asserted mid-transfer: reset values apply on the next clk; the transfer is lost.

Test Plan:
- Single-ended MSB first:
  - Stimulus: ch0_data=0xA5C, master sends 1,1,0,1 (start, SGL=1, ODD=0, MSBF=1).
  - Required: dout over the following falling edges = 0 (null), then 1,0,1,0,0,1,0,1,1,1,0,0; xfer_done pulses once; cfg_sgl=1, cfg_odd=0, cfg_msbf=1; dout_oe=0 within 3 clk of cs high.
- Channel select with leading zeros:
  - Stimulus: ch1_data=0x123, master sends 0,0,1,1,1,1.
  - Required: the leading zeros are ignored; result bits = 0x123 MSB first.
- Differential, both directions:
  - Stimulus: ch0=0x300, ch1=0x100.
  - SGL=0, ODD=0: 12 data bits = 0x200.
  - SGL=0, ODD=1: 12 data bits = 0x000 (clamped, no wrap).
- LSB-first tail:
  - Stimulus: ch0=0x801, SGL=1, ODD=0, MSBF=0.
  - Required: dout = 0, then 1,0,0,0,0,0,0,0,0,0,0,1, then 0,0,0,0,0,0,0,0,0,0,1 (B1..B11); xfer_done only after the final bit; DONE then holds dout=0.
- Abort and reset:
  - Stimulus: raise cs after the 5th data bit.
  - Required: dout_oe=0, no xfer_done; the next transfer decodes correctly.
  - Stimulus: assert rst for 1 clk mid-MSB_OUT.
  - Required: all outputs 0 on the following clk.
- Sampling instant:
  - Stimulus: change ch0_data from 0x0FF to 0xF00 while in MSB_OUT.
  - Required: the transmitted result stays 0x0FF.

Source files
------------

// File: rtl/mcp_adc_responder_if.sv
// SPI pins between the MCP master and the emulated MCP3202 ADC.
// dout_oe stands in for the ADC's tri-state dout driver.
interface mcp_adc_responder_if;
    logic cs;
    logic sclk;
    logic din;
    logic dout;
    logic dout_oe;

    modport master (output cs, output sclk, output din, input dout, input dout_oe);
    modport slave  (input cs, input sclk, input din, output dout, output dout_oe);
endinterface

// File: rtl/mcp_adc_responder.sv
// MCP3202-style SPI ADC emulator: decodes start/SGL/ODD/MSBF from the master and
// shifts a DATA_W-bit result back, all in the clk domain via oversampled SPI pins.
module mcp_adc_responder #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    mcp_adc_responder_if.slave  spi,
    input  logic [DATA_W-1:0]   ch0_data,
    input  logic [DATA_W-1:0]   ch1_data,
    output logic                busy,
    output logic                cfg_sgl,
    output logic                cfg_odd,
    output logic                cfg_msbf,
    output logic                xfer_done
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_CFG,
        ST_NULL,
        ST_MSB_OUT,
        ST_LSB_OUT,
        ST_DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   sclk_prev;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   din_s;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       msb_idx;
    logic                   sgl_q;
    logic                   odd_q;
    logic [DATA_W-1:0]      result_q;
    logic                   dout_q;
    logic                   dout_oe_q;

    // Differential modes subtract at DATA_W+1 bits so a borrow clamps to zero.
    function automatic logic [DATA_W-1:0] convert(input logic              sgl,
                                                  input logic              odd,
                                                  input logic [DATA_W-1:0] ch0,
                                                  input logic [DATA_W-1:0] ch1);
        logic [DATA_W:0] diff;
        if (sgl) begin
            return odd ? ch1 : ch0;
        end
        diff = odd ? ({1'b0, ch1} - {1'b0, ch0}) : ({1'b0, ch0} - {1'b0, ch1});
        return diff[DATA_W] ? '0 : diff[DATA_W-1:0];
    endfunction

    // Idle levels (cs high, sclk low) keep the edge detector quiet out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            din_sync  <= '0;
            sclk_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so each stage samples its pre-edge neighbour.
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], spi.din};
            sclk_prev <= sclk_s;
        end
    end

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign din_s     = din_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign msb_idx   = LAST_BIT - bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            sgl_q     <= 1'b0;
            odd_q     <= 1'b0;
            result_q  <= '0;
            dout_q    <= 1'b0;
            dout_oe_q <= 1'b0;
            cfg_sgl   <= 1'b0;
            cfg_odd   <= 1'b0;
            cfg_msbf  <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            // A deasserted cs overrides any sclk edge seen in the same cycle.
            if (cs_s) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                dout_q    <= 1'b0;
                dout_oe_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        bit_cnt <= '0;
                        state   <= ST_WAIT_START;
                    end

                    ST_WAIT_START: begin
                        if (sclk_rise && din_s) begin
                            bit_cnt <= '0;
                            state   <= ST_CFG;
                        end
                    end

                    ST_CFG: begin
                        if (sclk_rise) begin
                            if (bit_cnt == CNT_W'(0)) begin
                                sgl_q   <= din_s;
                                bit_cnt <= bit_cnt + 1'b1;
                            end else if (bit_cnt == CNT_W'(1)) begin
                                odd_q   <= din_s;
                                bit_cnt <= bit_cnt + 1'b1;
                            end else begin
                                // MSBF edge is the sampling instant of the conversion.
                                cfg_sgl  <= sgl_q;
                                cfg_odd  <= odd_q;
                                cfg_msbf <= din_s;
                                result_q <= convert(sgl_q, odd_q, ch0_data, ch1_data);
                                bit_cnt  <= '0;
                                state    <= ST_NULL;
                            end
                        end
                    end

                    ST_NULL: begin
                        if (sclk_fall) begin
                            dout_q    <= 1'b0;
                            dout_oe_q <= 1'b1;
                            bit_cnt   <= '0;
                            state     <= ST_MSB_OUT;
                        end
                    end

                    ST_MSB_OUT: begin
                        if (sclk_fall) begin
                            dout_q <= result_q[msb_idx];
                            if (bit_cnt == LAST_BIT) begin
                                if (cfg_msbf) begin
                                    xfer_done <= 1'b1;
                                    state     <= ST_DONE;
                                end else begin
                                    // B0 was just sent, so the LSB-first tail resumes at B1.
                                    bit_cnt <= CNT_W'(1);
                                    state   <= ST_LSB_OUT;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_LSB_OUT: begin
                        if (sclk_fall) begin
                            dout_q <= result_q[bit_cnt];
                            if (bit_cnt == LAST_BIT) begin
                                xfer_done <= 1'b1;
                                state     <= ST_DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    ST_DONE: begin
                        // The last data bit stays valid for the master's next rising edge.
                        if (sclk_fall) begin
                            dout_q <= 1'b0;
                        end
                        dout_oe_q <= 1'b1;
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign spi.dout    = dout_q;
    assign spi.dout_oe = dout_oe_q;
    assign busy        = ~cs_s;
endmodule

// File: tb/tb_mcp_adc_responder.sv
// Self-checking bench for mcp_adc_responder: a bit-banged SPI master plus a
// scoreboard of expected dout bits derived from an integer ADC model.
module tb_mcp_adc_responder;
    localparam int DATA_W = 12;
    localparam int HALF   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] ch0_data;
    logic [DATA_W-1:0] ch1_data;
    logic              busy;
    logic              cfg_sgl;
    logic              cfg_odd;
    logic              cfg_msbf;
    logic              xfer_done;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;
    logic exp_q[$];

    mcp_adc_responder_if spi();

    mcp_adc_responder #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .spi       (spi),
        .ch0_data  (ch0_data),
        .ch1_data  (ch1_data),
        .busy      (busy),
        .cfg_sgl   (cfg_sgl),
        .cfg_odd   (cfg_odd),
        .cfg_msbf  (cfg_msbf),
        .xfer_done (xfer_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (xfer_done === 1'b1) done_cnt++;
    end

    function automatic logic [DATA_W-1:0] model(input logic sgl, input logic odd,
                                                input logic [DATA_W-1:0] c0,
                                                input logic [DATA_W-1:0] c1);
        int a;
        int b;
        int d;
        a = int'(c0);
        b = int'(c1);
        if (sgl) d = odd ? b : a;
        else     d = odd ? (b - a) : (a - b);
        if (d < 0) d = 0;
        return d[DATA_W-1:0];
    endfunction

    // One full sclk period; dout is sampled late in the low phase, just before the rise.
    task automatic clock_bit(input logic b, output logic so, output logic soe);
        // NOTE: stimulus uses blocking assignments at negedge clk, clear of the DUT's sampling edge.
        spi.din = b;
        repeat (HALF) @(negedge clk);
        so  = spi.dout;
        soe = spi.dout_oe;
        spi.sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        spi.sclk = 1'b0;
    endtask

    // Drives one transfer; abort_after>=0 raises cs after that many data bits.
    task automatic run_xfer(input string name, input int nlead, input logic sgl,
                            input logic odd, input logic msbf, input int abort_after,
                            input int mid_at, input logic [DATA_W-1:0] mid_ch0);
        logic [DATA_W-1:0] res;
        logic so;
        logic soe;
        logic exp;
        int   nsamp;
        int   n_before;
        res = model(sgl, odd, ch0_data, ch1_data);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(res[i]);
        if (!msbf) for (int i = 1; i < DATA_W; i++) exp_q.push_back(res[i]);
        exp_q.push_back(1'b0);
        nsamp    = (abort_after >= 0) ? (1 + abort_after) : exp_q.size();
        n_before = done_cnt;

        spi.cs = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({busy, spi.dout_oe} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s cmd_phase: busy=%b dout_oe=%b, required busy=1 dout_oe=0",
                     name, busy, spi.dout_oe);
        end
        for (int i = 0; i < nlead; i++) clock_bit(1'b0, so, soe);
        clock_bit(1'b1, so, soe);
        clock_bit(sgl, so, soe);
        clock_bit(odd, so, soe);
        clock_bit(msbf, so, soe);

        for (int k = 0; k < nsamp; k++) begin
            if (k == mid_at) ch0_data = mid_ch0;
            spi.din = 1'b0;
            repeat (HALF) @(negedge clk);
            exp = exp_q.pop_front();
            n_checks++;
            if (spi.dout !== exp || spi.dout_oe !== 1'b1) begin
                n_fail++;
                $display("FAIL %s bit%0d: dout=%b dout_oe=%b, required dout=%b dout_oe=1",
                         name, k, spi.dout, spi.dout_oe, exp);
            end
            if (abort_after < 0 && k == nsamp - 3) begin
                n_checks++;
                if (done_cnt !== n_before) begin
                    n_fail++;
                    $display("FAIL %s early_done: pulses=%0d, required 0", name, done_cnt - n_before);
                end
            end
            spi.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi.sclk = 1'b0;
        end

        spi.cs = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({spi.dout_oe, spi.dout, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL %s cs_release: dout_oe=%b dout=%b busy=%b, required all 0",
                     name, spi.dout_oe, spi.dout, busy);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        spi.cs   = 1'b1;
        spi.sclk = 1'b0;
        spi.din  = 1'b0;
        ch0_data = '0;
        ch1_data = '0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({spi.dout, spi.dout_oe, busy, cfg_sgl, cfg_odd, cfg_msbf, xfer_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required 0000000",
                     {spi.dout, spi.dout_oe, busy, cfg_sgl, cfg_odd, cfg_msbf, xfer_done});
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({spi.dout_oe, busy, xfer_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: dout_oe/busy/xfer_done=%b, required 000",
                     {spi.dout_oe, busy, xfer_done});
        end
    endtask

    task automatic check_end(input string name, input int n_before, input int exp_pulses,
                             input logic [2:0] exp_cfg);
        n_checks++;
        if (done_cnt - n_before !== exp_pulses) begin
            n_fail++;
            $display("FAIL %s xfer_done: pulses=%0d, required %0d", name, done_cnt - n_before, exp_pulses);
        end
        n_checks++;
        if ({cfg_sgl, cfg_odd, cfg_msbf} !== exp_cfg) begin
            n_fail++;
            $display("FAIL %s cfg: sgl/odd/msbf=%b, required %b", name, {cfg_sgl, cfg_odd, cfg_msbf}, exp_cfg);
        end
    endtask

    task automatic test_single_msb();
        int n0;
        ch0_data = 12'hA5C;
        ch1_data = 12'h000;
        n0 = done_cnt;
        run_xfer("single_msb", 0, 1'b1, 1'b0, 1'b1, -1, -1, '0);
        check_end("single_msb", n0, 1, 3'b101);
    endtask

    task automatic test_leading_zeros();
        int n0;
        ch0_data = 12'hFFF;
        ch1_data = 12'h123;
        n0 = done_cnt;
        run_xfer("lead_zeros", 2, 1'b1, 1'b1, 1'b1, -1, -1, '0);
        check_end("lead_zeros", n0, 1, 3'b111);
    endtask

    task automatic test_differential();
        int n0;
        ch0_data = 12'h300;
        ch1_data = 12'h100;
        n0 = done_cnt;
        run_xfer("diff_pos", 0, 1'b0, 1'b0, 1'b1, -1, -1, '0);
        check_end("diff_pos", n0, 1, 3'b001);
        n0 = done_cnt;
        run_xfer("diff_clamp", 0, 1'b0, 1'b1, 1'b1, -1, -1, '0);
        check_end("diff_clamp", n0, 1, 3'b011);
    endtask

    task automatic test_lsb_tail();
        int n0;
        ch0_data = 12'h801;
        ch1_data = 12'h7FE;
        n0 = done_cnt;
        run_xfer("lsb_tail", 0, 1'b1, 1'b0, 1'b0, -1, -1, '0);
        check_end("lsb_tail", n0, 1, 3'b100);
    endtask

    task automatic test_abort();
        int n0;
        ch0_data = 12'h6B7;
        ch1_data = 12'h5A3;
        n0 = done_cnt;
        run_xfer("abort", 1, 1'b1, 1'b0, 1'b1, 5, -1, '0);
        check_end("abort", n0, 0, 3'b101);
        n0 = done_cnt;
        run_xfer("after_abort", 0, 1'b1, 1'b1, 1'b1, -1, -1, '0);
        check_end("after_abort", n0, 1, 3'b111);
    endtask

    task automatic test_reset_mid();
        logic so;
        logic soe;
        ch0_data = 12'hFFF;
        spi.cs   = 1'b0;
        repeat (4) @(negedge clk);
        clock_bit(1'b1, so, soe);
        clock_bit(1'b1, so, soe);
        clock_bit(1'b0, so, soe);
        clock_bit(1'b1, so, soe);
        for (int i = 0; i < 4; i++) clock_bit(1'b0, so, soe);
        repeat (HALF) @(negedge clk);
        n_checks++;
        if (spi.dout_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: dout_oe=%b, required 1", spi.dout_oe);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({spi.dout, spi.dout_oe, busy, cfg_sgl, cfg_odd, cfg_msbf, xfer_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b, required 0000000",
                     {spi.dout, spi.dout_oe, busy, cfg_sgl, cfg_odd, cfg_msbf, xfer_done});
        end
        spi.cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_sampling_instant();
        int n0;
        ch0_data = 12'h0FF;
        ch1_data = 12'h000;
        n0 = done_cnt;
        run_xfer("sample_hold", 0, 1'b1, 1'b0, 1'b1, -1, 4, 12'hF00);
        check_end("sample_hold", n0, 1, 3'b101);
    endtask

    task automatic test_back_to_back();
        int n0;
        ch0_data = 12'h050;
        ch1_data = 12'hABC;
        n0 = done_cnt;
        run_xfer("b2b_a", 0, 1'b0, 1'b1, 1'b0, -1, -1, '0);
        ch0_data = 12'hC3A;
        run_xfer("b2b_b", 0, 1'b1, 1'b0, 1'b1, -1, -1, '0);
        check_end("b2b", n0, 2, 3'b101);
    endtask

    initial begin
        test_reset();
        test_single_msb();
        test_leading_zeros();
        test_differential();
        test_lsb_tail();
        test_abort();
        test_reset_mid();
        test_sampling_instant();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
